// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and the ID-stage forwarding select function for the
// pipeline hazard controller.
package pipeline_ctrl_pkg;

  // Operand source select for the ID-stage forwarding muxes
  typedef enum logic [1:0] {
    FWD_RF      = 2'd0,
    FWD_ALU_EXE = 2'd1,
    FWD_ALU_MEM = 2'd2,
    FWD_LMD_MEM = 2'd3
  } fwd_sel_e;

  // Sequencer states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2,
    STEP     = 2'd3
  } ctrl_state_e;

  // What the stage rst/en pairs do in a given cycle
  typedef enum logic [1:0] {
    PAT_ADV = 2'd0,
    PAT_LU  = 2'd1,
    PAT_FRZ = 2'd2
  } stage_pat_e;

  localparam logic [4:0] GPR_ZERO = 5'd0;

  // EXE result wins over MEM; a load still in EXE has no data yet, and $0 is
  // hard-wired so it is never forwarded.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] src,
    input logic [4:0] exe_addr,
    input logic       exe_wen,
    input logic       exe_load,
    input logic [4:0] mem_addr,
    input logic       mem_wen,
    input logic       mem_load
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (exe_wen && !exe_load && exe_addr != GPR_ZERO && exe_addr == src)
      sel = FWD_ALU_EXE;
    else if (mem_wen && mem_addr != GPR_ZERO && mem_addr == src)
      sel = mem_load ? FWD_LMD_MEM : FWD_ALU_MEM;
    return sel;
  endfunction

endpackage

// File: rtl/debug_step_sync.sv
// Brings the raw debug step button into the clk domain and turns each press
// into a single-cycle pulse.
module debug_step_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_step_raw,
  output logic o_step_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  // Two-flop synchroniser followed by one delay flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_step_raw;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_step_pulse = r_sync & ~r_sync_d;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage delayed-branch datapath: load-use stalls,
// ID-stage forwarding selects, memory-wait freeze with timeout, single-step.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   debug_en,
  input  logic                   debug_step,
  input  logic [31:0]            inst_data_id,
  input  logic                   rs_used_id,
  input  logic                   rt_used_id,
  input  logic [4:0]             regw_addr_exe,
  input  logic                   wb_wen_exe,
  input  logic                   is_load_exe,
  input  logic [4:0]             regw_addr_mem,
  input  logic                   wb_wen_mem,
  input  logic                   is_load_mem,
  input  logic                   mem_req,
  input  logic                   mem_ack,
  output logic                   if_rst,
  output logic                   id_rst,
  output logic                   exe_rst,
  output logic                   mem_rst,
  output logic                   wb_rst,
  output logic                   if_en,
  output logic                   id_en,
  output logic                   exe_en,
  output logic                   mem_en,
  output logic                   wb_en,
  output logic [1:0]             exe_fwd_a_ctrl,
  output logic [1:0]             exe_fwd_b_ctrl,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

  ctrl_state_e             r_state;
  ctrl_state_e             w_state_nxt;
  stage_pat_e              w_pat;
  logic [WAIT_W-1:0]       r_wait_cnt;
  logic [WAIT_W-1:0]       w_wait_nxt;
  logic                    w_set_err;
  logic                    r_mem_err;
  logic [STALL_CNT_W-1:0]  r_stall_cnt;
  logic                    w_step_pulse;
  logic [4:0]              w_rs;
  logic [4:0]              w_rt;
  logic                    w_lu;
  logic                    w_mem_stall;
  logic                    w_timeout;
  stage_pat_e              w_adv_pat;
  logic                    w_unused_inst;

  debug_step_sync u_step_sync (
    .clk          (clk),
    .rst          (rst),
    .i_step_raw   (debug_step),
    .o_step_pulse (w_step_pulse)
  );

  assign w_rs          = inst_data_id[25:21];
  assign w_rt          = inst_data_id[20:16];
  assign w_unused_inst = ^{inst_data_id[31:26], inst_data_id[15:0]};

  assign w_lu = is_load_exe & wb_wen_exe & (regw_addr_exe != GPR_ZERO) &
                ((rs_used_id & (w_rs == regw_addr_exe)) |
                 (rt_used_id & (w_rt == regw_addr_exe)));

  assign w_mem_stall = mem_req & ~mem_ack;
  assign w_timeout   = (MEM_TIMEOUT != 0) && (32'(r_wait_cnt) >= MEM_TIMEOUT);
  // Any cycle that lets instructions move must still respect load-use,
  // including the release out of a memory wait.
  assign w_adv_pat   = w_lu ? PAT_LU : PAT_ADV;

  // Next-state, stage pattern and wait-counter update
  always_comb begin
    w_state_nxt = r_state;
    w_pat       = PAT_FRZ;
    w_wait_nxt  = '0;
    w_set_err   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_wait_nxt  = WAIT_W'(1);
          w_state_nxt = MEM_WAIT;
        end else if (debug_en) begin
          w_state_nxt = HALT;
        end else begin
          w_pat = w_adv_pat;
        end
      end
      MEM_WAIT: begin
        if (mem_ack || w_timeout) begin
          w_pat       = w_adv_pat;
          w_set_err   = ~mem_ack;
          w_state_nxt = debug_en ? HALT : RUN;
        end else begin
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      HALT: begin
        if (!debug_en)
          w_state_nxt = RUN;
        else if (w_step_pulse)
          w_state_nxt = STEP;
      end
      STEP: begin
        if (w_mem_stall) begin
          w_wait_nxt  = WAIT_W'(1);
          w_state_nxt = MEM_WAIT;
        end else begin
          w_pat       = w_adv_pat;
          w_state_nxt = HALT;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Stage rst/en drive; reset forces every stage into reset immediately
  always_comb begin
    {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b00000;
    {if_en, id_en, exe_en, mem_en, wb_en}      = 5'b00000;
    if (rst) begin
      {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = 5'b11111;
    end else begin
      case (w_pat)
        PAT_ADV: {if_en, id_en, exe_en, mem_en, wb_en} = 5'b11111;
        PAT_LU: begin
          {if_en, id_en, exe_en, mem_en, wb_en} = 5'b00111;
          exe_rst = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Forwarding selects, held at regfile while in reset
  always_comb begin
    exe_fwd_a_ctrl = FWD_RF;
    exe_fwd_b_ctrl = FWD_RF;
    if (!rst) begin
      exe_fwd_a_ctrl = fwd_select(w_rs, regw_addr_exe, wb_wen_exe, is_load_exe,
                                  regw_addr_mem, wb_wen_mem, is_load_mem);
      exe_fwd_b_ctrl = fwd_select(w_rt, regw_addr_exe, wb_wen_exe, is_load_exe,
                                  regw_addr_mem, wb_wen_mem, is_load_mem);
    end
  end

  // State, wait counter, sticky error and saturating stall statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_set_err)
        r_mem_err <= 1'b1;
      if (w_pat != PAT_ADV && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: expected per-cycle outputs are
// queued as stimulus is driven and compared when sampled on the falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int SCW = 8;

  // {if_rst,id_rst,exe_rst,mem_rst,wb_rst, if_en,id_en,exe_en,mem_en,wb_en}
  localparam logic [9:0] P_RST = 10'b11111_00000;
  localparam logic [9:0] P_ADV = 10'b00000_11111;
  localparam logic [9:0] P_LU  = 10'b00100_00111;
  localparam logic [9:0] P_FRZ = 10'b00000_00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, debug_en, debug_step;
  logic [31:0]    inst_data_id;
  logic           rs_used_id, rt_used_id;
  logic [4:0]     regw_addr_exe, regw_addr_mem;
  logic           wb_wen_exe, is_load_exe, wb_wen_mem, is_load_mem;
  logic           mem_req, mem_ack;
  logic           if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic           if_en, id_en, exe_en, mem_en, wb_en;
  logic [1:0]     exe_fwd_a_ctrl, exe_fwd_b_ctrl;
  logic           mem_err;
  logic [SCW-1:0] stall_cnt;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .inst_data_id(inst_data_id), .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe), .is_load_exe(is_load_exe),
    .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem), .is_load_mem(is_load_mem),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .exe_fwd_a_ctrl(exe_fwd_a_ctrl), .exe_fwd_b_ctrl(exe_fwd_b_ctrl),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [9:0]     pat;
    logic [1:0]     fa;
    logic [1:0]     fb;
    logic [SCW-1:0] sc;
    logic           err;
  } exp_t;

  exp_t           sb[$];
  int             total = 0;
  int             bad = 0;
  logic [SCW-1:0] m_sc = '0;
  logic           m_err = 1'b0;

  function automatic exp_t observe();
    exp_t o;
    o.pat = {if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en};
    o.fa  = exe_fwd_a_ctrl;
    o.fb  = exe_fwd_b_ctrl;
    o.sc  = stall_cnt;
    o.err = mem_err;
    return o;
  endfunction

  // Queue the expectation for the cycle just driven and advance the model of
  // the registered statistics (visible from the next cycle on).
  task automatic expect_cycle(input logic [9:0] pat, input logic [1:0] fa,
                              input logic [1:0] fb, input logic set_err);
    exp_t e;
    e.pat = pat; e.fa = fa; e.fb = fb; e.sc = m_sc; e.err = m_err;
    sb.push_back(e);
    if (pat == P_RST) begin
      m_sc  = '0;
      m_err = 1'b0;
    end else begin
      if (pat != P_ADV && m_sc != '1) m_sc = m_sc + 1'b1;
      if (set_err) m_err = 1'b1;
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu,
                        input logic [4:0] ea, input logic ew, input logic el,
                        input logic [4:0] ma, input logic mw, input logic ml);
    inst_data_id  = {6'b000000, rs, rt, 16'h0000};
    rs_used_id    = rsu;
    rt_used_id    = rtu;
    regw_addr_exe = ea; wb_wen_exe = ew; is_load_exe = el;
    regw_addr_mem = ma; wb_wen_mem = mw; is_load_mem = ml;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    rst = 1'b1; debug_en = 1'b0; debug_step = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    set_in(5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      expect_cycle(P_RST, 2'd0, 2'd0, 1'b0);
      @(negedge clk);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin
        bad++; $display("FAIL reset[%0d] got=%h want=%h", i, o, e);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    exp_t e, o;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(P_ADV, 0, 0, 0); end
        // lw $2 in EXE, add $3,$2,$1 in ID
        1: begin set_in(2, 1, 1, 1, 2, 1, 1, 0, 0, 0); expect_cycle(P_LU, 0, 0, 0); end
        // bubble in EXE, load now in MEM
        2: begin set_in(2, 1, 1, 1, 0, 0, 0, 2, 1, 1); expect_cycle(P_ADV, 3, 0, 0); end
        // rt matches the load but rt is not read: no stall
        3: begin set_in(7, 2, 1, 0, 2, 1, 1, 0, 0, 0); expect_cycle(P_ADV, 0, 0, 0); end
        default: begin set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cycle(P_ADV, 0, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin
        bad++; $display("FAIL load_use[%0d] got=%h want=%h", i, o, e);
      end
      if (i == 2) begin
        total++;
        if (stall_cnt !== 8'd1) begin
          bad++; $display("FAIL load_use_stall_cnt got=%0d want=1", stall_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_forward();
    exp_t e, o;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin set_in(4, 5, 1, 1, 4, 1, 0, 0, 0, 0); expect_cycle(P_ADV, 1, 0, 0); end
        1: begin set_in(4, 5, 1, 1, 0, 0, 0, 4, 1, 0); expect_cycle(P_ADV, 2, 0, 0); end
        2: begin set_in(4, 5, 1, 1, 4, 1, 0, 4, 1, 0); expect_cycle(P_ADV, 1, 0, 0); end
        3: begin set_in(4, 5, 1, 1, 5, 1, 0, 4, 1, 1); expect_cycle(P_ADV, 3, 1, 0); end
        4: begin set_in(4, 5, 1, 1, 4, 0, 0, 5, 1, 1); expect_cycle(P_ADV, 0, 3, 0); end
        default: begin set_in(4, 5, 0, 1, 4, 1, 1, 0, 0, 0); expect_cycle(P_ADV, 0, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin
        bad++; $display("FAIL forward[%0d] got=%h want=%h", i, o, e);
      end
      tick();
    end
  endtask

  task automatic test_reg_zero();
    exp_t e, o;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) set_in(0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
      else        set_in(0, 0, 1, 1, 0, 1, 0, 0, 1, 1);
      expect_cycle(P_ADV, 0, 0, 0);
      @(negedge clk);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin
        bad++; $display("FAIL reg_zero[%0d] got=%h want=%h", i, o, e);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    exp_t e, o;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // short wait: 3 frozen, ack on 4th, then idle; long wait: 16 frozen,
    // forced release on 17th, then idle
    for (int i = 0; i < 24; i++) begin
      if (i < 3)       begin mem_req = 1; mem_ack = 0; expect_cycle(P_FRZ, 0, 0, 0); end
      else if (i == 3) begin mem_req = 1; mem_ack = 1; expect_cycle(P_ADV, 0, 0, 0); end
      else if (i == 4) begin mem_req = 0; mem_ack = 0; expect_cycle(P_ADV, 0, 0, 0); end
      else if (i < 21) begin mem_req = 1; mem_ack = 0; expect_cycle(P_FRZ, 0, 0, 0); end
      else if (i == 21) begin mem_req = 1; mem_ack = 0; expect_cycle(P_ADV, 0, 0, 1); end
      else             begin mem_req = 0; mem_ack = 0; expect_cycle(P_ADV, 0, 0, 0); end
      @(negedge clk);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin
        bad++; $display("FAIL mem_wait[%0d] got=%h want=%h", i, o, e);
      end
      if (i == 4 || i == 22) begin
        total++;
        if (mem_err !== (i == 22)) begin
          bad++; $display("FAIL mem_err[%0d] got=%b want=%b", i, mem_err, (i == 22));
        end
      end
      tick();
    end
  endtask

  task automatic test_debug();
    exp_t e, o;
    int   adv;
    adv = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 26; i++) begin
      rst = 1'b0;
      debug_en = 1'b1;
      debug_step = 1'b0;
      if (i < 3) begin
        expect_cycle(P_FRZ, 0, 0, 0);
      end else if (i < 19) begin
        // presses at offsets 0..3 and 8..11; step advances at offsets 3 and 11
        debug_step = ((i - 3) % 8) < 4;
        expect_cycle(((i - 3) == 3 || (i - 3) == 11) ? P_ADV : P_FRZ, 0, 0, 0);
      end else if (i == 19) begin
        debug_en = 1'b0; expect_cycle(P_FRZ, 0, 0, 0);
      end else if (i == 20) begin
        debug_en = 1'b0; expect_cycle(P_ADV, 0, 0, 0);
      end else if (i < 23) begin
        expect_cycle(P_FRZ, 0, 0, 0);
      end else if (i == 23) begin
        rst = 1'b1; expect_cycle(P_RST, 0, 0, 0);
      end else begin
        debug_en = 1'b0; expect_cycle(P_ADV, 0, 0, 0);
      end
      @(negedge clk);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin
        bad++; $display("FAIL debug[%0d] got=%h want=%h", i, o, e);
      end
      if (i >= 3 && i < 19 && if_en === 1'b1) adv++;
      tick();
    end
    rst = 1'b0;
    total++;
    if (adv !== 2) begin
      bad++; $display("FAIL debug_step_count got=%0d want=2", adv);
    end
  endtask

  task automatic test_saturate();
    exp_t e, o;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    debug_en = 1'b1;
    for (int i = 0; i < 270; i++) begin
      expect_cycle(P_FRZ, 0, 0, 0);
      @(negedge clk);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin
        bad++; $display("FAIL saturate[%0d] got=%h want=%h", i, o, e);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (stall_cnt !== 8'hFF) begin
      bad++; $display("FAIL stall_saturate got=%0d want=255", stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_reg_zero();
    test_mem_wait();
    test_debug();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
